// File: rtl/crc_frame_tx.sv
// Frames a 16-bit word as [sync] + data + CRC-8 (poly 0xB3) and shifts it out MSB-first at the bit_en rate.
// First bit on ser_out 1 clk after accept; in_ready stays low for the whole frame, so upstream stalls until IDLE.

module crc8_d16 (
    input  logic [15:0] data,
    output logic [7:0]  crc
);
    localparam logic [7:0] POLY = 8'hB3;

    function automatic logic [7:0] crc8(input logic [15:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 15; i >= 0; i--)
            c = {c[6:0], 1'b0} ^ (((c[7] ^ d[i]) == 1'b1) ? POLY : 8'h00);
        return c;
    endfunction

    assign crc = crc8(data);
endmodule

module crc_frame_tx #(
    parameter bit         SYNC_EN   = 1'b1,
    parameter logic [7:0] SYNC_WORD = 8'h7E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        bit_en,
    output logic        ser_out,
    output logic        ser_valid,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    typedef enum logic [1:0] {IDLE, SYNC, DATA, CRC} state_t;

    // bit_cnt counts across the whole frame, so segment ends depend on whether a sync byte leads
    localparam logic [4:0] SYNC_LAST = 5'd7;
    localparam logic [4:0] DATA_LAST = SYNC_EN ? 5'd23 : 5'd15;
    localparam logic [4:0] CRC_LAST  = SYNC_EN ? 5'd31 : 5'd23;

    state_t      state;
    logic [31:0] shreg;
    logic [4:0]  bit_cnt;
    logic [7:0]  crc;
    logic        accept;

    crc8_d16 u_crc (
        .data (in_data),
        .crc  (crc)
    );

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    // shreg is left-aligned and drains to zero, so the MSB doubles as the registered serial output
    assign ser_out   = shreg[31];
    assign ser_valid = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= 32'h0;
            bit_cnt    <= 5'd0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    shreg   <= SYNC_EN ? {SYNC_WORD, in_data, crc} : {in_data, crc, 8'h00};
                    bit_cnt <= 5'd0;
                    state   <= SYNC_EN ? SYNC : DATA;
                end
            end else if (bit_en) begin
                shreg   <= {shreg[30:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
                if (state == SYNC && bit_cnt == SYNC_LAST)
                    state <= DATA;
                if (state == DATA && bit_cnt == DATA_LAST)
                    state <= CRC;
                if (state == CRC && bit_cnt == CRC_LAST) begin
                    state      <= IDLE;
                    bit_cnt    <= 5'd0;
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_crc_frame_tx.sv
// Scoreboarded bench: stimulus pushes expected frame bits and frame counts; a negedge monitor checks them.
module tb_crc_frame_tx;
    logic        clk = 1'b0;
    logic [1:0]  rst, in_valid, bit_en, in_ready, ser_out, ser_valid, frame_done;
    logic [15:0] in_data   [2];
    logic [15:0] frame_cnt [2];

    always #5 clk = ~clk;

    // instance 0 has no sync byte, instance 1 prepends 0x7E
    crc_frame_tx #(.SYNC_EN(1'b0), .SYNC_WORD(8'h7E)) u0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .bit_en(bit_en[0]), .ser_out(ser_out[0]),
        .ser_valid(ser_valid[0]), .frame_done(frame_done[0]), .frame_cnt(frame_cnt[0])
    );
    crc_frame_tx #(.SYNC_EN(1'b1), .SYNC_WORD(8'h7E)) u1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .bit_en(bit_en[1]), .ser_out(ser_out[1]),
        .ser_valid(ser_valid[1]), .frame_done(frame_done[1]), .frame_cnt(frame_cnt[1])
    );

    typedef struct packed { logic inst; logic b; logic last; } exp_t;
    exp_t        exp_q [$];
    logic [15:0] cnt_q [$];
    logic [15:0] exp_cnt [2];
    logic [1:0]  done_due = 2'b00;
    exp_t        e;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int k, input logic [15:0] d, input logic [7:0] c);
        logic [31:0] f;
        int          n;
        if (k == 1) begin f = {8'h7E, d, c};  n = 32; end
        else        begin f = {d, c, 8'h00};  n = 24; end
        for (int i = 0; i < n; i++)
            exp_q.push_back(exp_t'{k[0], f[31-i], i == n - 1});
        exp_cnt[k] = exp_cnt[k] + 16'd1;
        cnt_q.push_back(exp_cnt[k]);
    endtask

    task automatic send(input int k, input logic [15:0] d, input logic [7:0] c, input bit hold);
        int t = 0;
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && t < 100) begin tick(); t++; end
        chk("accept_wait", k, 32'(in_ready[k]), 1);
        push_frame(k, d, c);
        tick();
        in_valid[k] = hold;
    endtask

    // Sends one word and paces bit_en every `period` clocks; hold keeps in_valid high with churning data.
    task automatic run_frame(input int k, input logic [15:0] d, input logic [7:0] c,
                             input int period, input bit hold);
        int n, t, vcyc;
        n = (k == 1) ? 32 : 24;
        t = 0;
        vcyc = 0;
        bit_en[k] = (period == 1);
        send(k, d, c, hold);
        chk("first_bit_valid", k, 32'(ser_valid[k]), 1);
        while (t < n * period + 8) begin
            bit_en[k] = ((t % period) == period - 1);
            if (hold) in_data[k] = ~in_data[k];
            if (ser_valid[k]) begin
                vcyc++;
                chk("ready_busy", k, 32'(in_ready[k]), 0);
            end
            tick();
            t++;
            if (frame_done[k]) break;
        end
        bit_en[k] = 1'b0;
        chk("done_cycle", k, 32'(t), 32'(n * period));
        chk("valid_cycles", k, 32'(vcyc), 32'(n * period));
        chk("idle_ready", k, 32'(in_ready[k]), 1);
        chk("idle_valid", k, 32'(ser_valid[k]), 0);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("frame_done", k, 32'(frame_done[k]), 32'(done_due[k]));
            if (frame_done[k]) begin
                if (cnt_q.size() == 0) chk("done_extra", k, 1, 0);
                else chk("frame_cnt", k, 32'(frame_cnt[k]), 32'(cnt_q.pop_front()));
            end
            done_due[k] = 1'b0;
            if (!ser_valid[k]) begin
                chk("idle_ser_out", k, 32'(ser_out[k]), 0);
            end else if (bit_en[k]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", k, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bit_inst", k, 32'(k), 32'(e.inst));
                    chk("ser_bit", k, 32'(ser_out[k]), 32'(e.b));
                    if (e.last) done_due[k] = 1'b1;
                end
            end
        end
    end

    initial begin
        rst        = 2'b11;
        in_valid   = 2'b00;
        bit_en     = 2'b00;
        in_data[0] = 16'h0;
        in_data[1] = 16'h0;
        exp_cnt[0] = 16'h0;
        exp_cnt[1] = 16'h0;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", k, 32'(in_ready[k]), 0);
            chk("rst_valid", k, 32'(ser_valid[k]), 0);
            chk("rst_cnt", k, 32'(frame_cnt[k]), 0);
        end
        rst = 2'b00;
        #1;
        chk("ready_out_of_rst", 0, 32'(in_ready[0]), 1);
        tick();

        run_frame(0, 16'h0001, 8'hB3, 1, 1'b0);
        run_frame(1, 16'h8000, 8'hEF, 1, 1'b0);
        run_frame(1, 16'h0100, 8'h8C, 4, 1'b0);
        run_frame(0, 16'h0001, 8'hB3, 1, 1'b1);
        run_frame(0, 16'h8000, 8'hEF, 1, 1'b0);

        // abort mid-frame: reset lands between clock edges after 10 bits
        bit_en[0] = 1'b1;
        send(0, 16'h0001, 8'hB3, 1'b0);
        repeat (10) tick();
        #3;
        rst[0] = 1'b1;
        exp_q.delete();
        cnt_q.delete();
        exp_cnt[0] = 16'h0;
        #1;
        chk("abort_valid", 0, 32'(ser_valid[0]), 0);
        chk("abort_ser_out", 0, 32'(ser_out[0]), 0);
        chk("abort_cnt", 0, 32'(frame_cnt[0]), 0);
        chk("abort_ready", 0, 32'(in_ready[0]), 0);
        tick();
        tick();
        rst[0] = 1'b0;
        bit_en[0] = 1'b0;
        tick();

        run_frame(0, 16'h0000, 8'h00, 1, 1'b1);
        run_frame(0, 16'h0001, 8'hB3, 1, 1'b1);
        run_frame(0, 16'h8000, 8'hEF, 1, 1'b0);

        tick();
        force u0.frame_cnt = 16'hFFFF;
        #2;
        release u0.frame_cnt;
        exp_cnt[0] = 16'hFFFF;
        chk("forced_cnt", 0, 32'(frame_cnt[0]), 32'h0000FFFF);
        tick();
        run_frame(0, 16'h0100, 8'h8C, 1, 1'b0);

        repeat (3) tick();
        chk("bits_left", 0, 32'(exp_q.size()), 0);
        chk("counts_left", 0, 32'(cnt_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/crc_frame_tx.md
Name: crc_frame_tx

Overview:
Bit-serial frame transmitter that sits directly downstream of the combinational CRC module (16-bit data in, CRC-8 poly x^8+x^7+x^5+x^4+x+1 out). It accepts one 16-bit word per valid/ready handshake and instantiates CRC internally. Each frame is serialized MSB-first as an optional sync byte, then the 16 data bits, then the 8 CRC bits. Bit rate is paced by an external bit-enable strobe.

Parameters:
SYNC_EN, 1, 1 = prepend SYNC_WORD to each frame; 0 = no sync byte.
SYNC_WORD, 8'h7E, sync byte, sent MSB-first.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  reset; asynchronous, active-high.
in_valid  input  1  upstream word available.
in_data  input  16  data word to frame.
in_ready  output  1  block can accept a word.
bit_en  input  1  bit-rate strobe; advances the serializer by one bit.
ser_out  output  1  serial data, MSB-first.
ser_valid  output  1  ser_out carries a frame bit.
frame_done  output  1  one-cycle pulse when the last frame bit is consumed.
frame_cnt  output  16  count of completed frames, wraps.

Behaviour:
- Reset (async): state IDLE; ser_out=0, ser_valid=0, frame_done=0, frame_cnt=0, shift register=0, bit counter=0. in_ready=0 while rst is high.
- CRC convention (fixed by the CRC module): init 0x00, no reflection, no final XOR. Reference values: 0x0000->0x00, 0x0001->0xB3, 0x0100->0x8C, 0x8000->0xEF.
- States: IDLE, SYNC, DATA, CRC.
- in_ready = (state==IDLE) && !rst, combinational from state.
- Accept: on a posedge with in_valid && in_ready:
  - load the shift register with {SYNC_WORD, in_data, crc_out(in_data)} (32 bits), or {in_data, crc} (24 bits) when SYNC_EN=0;
  - go to SYNC, or to DATA when SYNC_EN=0.
- ser_out is the MSB of the shift register, registered. ser_valid=1 in every state except IDLE.
- First bit is on ser_out the cycle after acceptance (latency 1 clk).
- Each bit is held until a cycle with bit_en=1. On that posedge the register shifts left and the bit counter increments.
- Transitions:
  - SYNC->DATA after 8 bits consumed.
  - DATA->CRC after 16 bits consumed.
  - CRC->IDLE after 8 bits consumed.
- Exit: on the posedge that consumes the final CRC bit:
  - frame_done=1 for exactly that next cycle;
  - frame_cnt increments, 0xFFFF wraps to 0x0000;
  - ser_valid=0 and ser_out=0 in IDLE.
- Frames are never back-to-back in one cycle: minimum one IDLE cycle (in_ready high) between frames.
- bit_en in IDLE: ignored.
- in_valid while not IDLE: ignored. in_data changes do not affect the frame in flight, which is fully captured at accept.
- bit_en and accept in the same IDLE cycle: accept only, no shift.
- rst asserted mid-frame: frame aborted immediately, all outputs return to reset values, no frame_done, frame_cnt cleared.
- Bit counter is 5 bits. Frame length is 32 bits (SYNC_EN=1) or 24 bits (SYNC_EN=0).

Test Plan:
1. SYNC_EN=0, bit_en=1 constant, send 0x0001:
   - ser_out = 15x'0', '1', then 1,0,1,1,0,0,1,1 (0xB3) over 24 consecutive cycles starting 1 clk after accept;
   - frame_done on cycle 25; frame_cnt=1; in_ready high next cycle.
2. SYNC_EN=1, SYNC_WORD=0x7E, bit_en=1, send 0x8000:
   - 32 bits = 01111110, 1000000000000000, 11101111 (0xEF);
   - ser_valid high exactly 32 cycles.
3. bit_en pulsed every 4th clk, send 0x0100:
   - each bit held 4 clks; CRC bits 10001100 (0x8C);
   - frame_done one cycle wide.
4. While a frame of 0x0001 is in flight, drive in_valid=1 with in_data toggling:
   - in_ready=0 throughout; serialized bits unchanged;
   - next word accepted only after the IDLE cycle.
5. Assert rst asynchronously (between clock edges) after 10 bits:
   - ser_valid/ser_out/frame_cnt go to 0 without waiting for a clk edge; no frame_done;
   - a subsequent 0x0000 frame is serialized as 24 zeros with CRC 0x00.
6. Send 3 frames back-to-back (in_valid held high): frame_cnt = 1, 2, 3. Force frame_cnt to 0xFFFF, complete one frame -> 0x0000.
